// File: rtl/list_reduce_pkg.sv
// Shared types for the list reduction engine: traversal states, fold modes
// and the null pointer value that terminates a list.
package list_reduce_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_VAL,
    WAIT_VAL,
    REQ_NEXT,
    WAIT_NEXT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_SUM = 2'b00,
    MODE_MAX = 2'b01,
    MODE_CNT = 2'b10,
    MODE_XOR = 2'b11
  } mode_t;

  localparam int NULL_PTR = 0;

endpackage

// File: rtl/list_reduce_alu.sv
// Combinational fold step: combines the running accumulator with one node
// value under the selected mode and reports a carry-out for sum/count.
import list_reduce_pkg::*;

module list_reduce_alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] value,
  input  mode_t             mode,
  output logic [DATA_W-1:0] next_acc,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide     = '0;
    next_acc = acc;
    carry    = 1'b0;
    case (mode)
      MODE_SUM: begin
        wide     = {1'b0, acc} + {1'b0, value};
        next_acc = wide[DATA_W-1:0];
        carry    = wide[DATA_W];
      end
      MODE_MAX: next_acc = (value > acc) ? value : acc;
      MODE_CNT: begin
        // Count ignores the node value; only the carry matters for wrap.
        wide     = {1'b0, acc} + {{DATA_W{1'b0}}, 1'b1};
        next_acc = wide[DATA_W-1:0];
        carry    = wide[DATA_W];
      end
      MODE_XOR: next_acc = acc ^ value;
      default:  next_acc = acc;
    endcase
  end

endmodule

// File: rtl/list_reduce_engine.sv
// Linked-list walker: fetches value/next pairs from a single-port memory with a
// variable-latency handshake and folds the values, aborting after MAX_NODES.
import list_reduce_pkg::*;

module list_reduce_engine #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_NODES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] head,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_NODES + 1);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   alu_acc;
  logic                alu_carry;

  list_reduce_alu #(.DATA_W(DATA_W)) u_alu (
    .acc      (acc_q),
    .value    (mem_rdata),
    .mode     (mode_q),
    .next_acc (alu_acc),
    .carry    (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          ptr_d   = head;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (head == ADDR_W'(NULL_PTR)) ? DONE : REQ_VAL;
        end
      end
      REQ_VAL:  state_d = WAIT_VAL;
      WAIT_VAL: begin
        if (mem_rvalid) begin
          acc_d   = alu_acc;
          ovf_d   = ovf_q | alu_carry;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = REQ_NEXT;
        end
      end
      REQ_NEXT: state_d = WAIT_NEXT;
      WAIT_NEXT: begin
        if (mem_rvalid) begin
          ptr_d = mem_rdata[ADDR_W-1:0];
          if (mem_rdata[ADDR_W-1:0] == ADDR_W'(NULL_PTR)) begin
            state_d = DONE;
          end else if (cnt_q == CNT_W'(MAX_NODES)) begin
            // Limit reached with more list ahead: treat as a runaway/cycle.
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ_VAL;
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    mem_req_d  = (state_d == REQ_VAL) || (state_d == REQ_NEXT);
    mem_addr_d = (state_d == REQ_NEXT) ? ptr_d + ADDR_W'(1) : ptr_d;
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_SUM;
      ptr_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = acc_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_list_reduce_engine.sv
// Self-checking bench for list_reduce_engine: fixed vectors, randomized lists
// against a list-walking reference model, and a mid-traversal reset sequence.
module tb_list_reduce_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode_in;
  logic [7:0]  head_in;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        err;

  int chk_total = 0;
  int err_count = 0;

  list_reduce_engine #(.DATA_W(32), .ADDR_W(8), .MAX_NODES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode_in),
    .head       (head_in),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .ovf        (ovf),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: random latency per read, drops reads on reset, and throws
  // stray rvalid pulses while the engine is idle or finished.
  logic [31:0] mem [256];
  int          lat_max = 1;
  logic        spur_en = 1'b0;
  logic        pend = 1'b0;
  int          wait_cnt = 0;
  logic [7:0]  pend_addr = 8'd0;
  int          req_total = 0;
  int          overlap_total = 0;
  int          lat;

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    mem_rdata  <= $urandom;
    if (rst) begin
      pend     <= 1'b0;
      wait_cnt <= 0;
    end else begin
      if (mem_req) begin
        req_total <= req_total + 1;
        if (pend) overlap_total <= overlap_total + 1;
      end
      if (pend) begin
        if (wait_cnt <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem[pend_addr];
          pend       <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end else if (mem_req) begin
        lat = (lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max));
        if (lat == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem[mem_addr];
        end else begin
          pend      <= 1'b1;
          pend_addr <= mem_addr;
          wait_cnt  <= lat - 1;
        end
      end else if (spur_en && !mem_rvalid && $urandom_range(0, 3) == 0) begin
        mem_rvalid <= 1'b1;
      end
    end
  end

  typedef struct {
    logic [7:0]  head;
    logic [1:0]  mode;
    logic [31:0] exp_result;
    logic        exp_ovf;
    logic        exp_err;
    int          exp_cycles;
    int          exp_reqs;
  } vec_t;

  // Reference: walk the list in the memory array and fold with plain arithmetic.
  function automatic void ref_walk(input logic [7:0] h, input logic [1:0] m,
                                   output logic [31:0] r, output logic o, output logic e);
    logic [7:0] p, q, nxt;
    longint unsigned acc;
    int n;
    acc = 0; o = 1'b0; e = 1'b0; n = 0; p = h;
    while (p != 8'd0) begin
      case (m)
        2'd0: acc = acc + longint'(mem[p]);
        2'd1: if (longint'(mem[p]) > acc) acc = longint'(mem[p]);
        2'd2: acc = acc + 1;
        default: acc = acc ^ longint'(mem[p]);
      endcase
      if (acc >= 64'h1_0000_0000) begin
        acc = acc - 64'h1_0000_0000;
        o = 1'b1;
      end
      n++;
      q = p + 8'd1;
      nxt = mem[q][7:0];
      if (nxt == 8'd0) break;
      if (n == 64) begin
        e = 1'b1;
        break;
      end
      p = nxt;
    end
    r = acc[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_total++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a run, scrambles mode/head while busy, and returns cycles to done.
  task automatic applyStimulus(input logic [7:0] h, input logic [1:0] m,
                               output int cycles, output int reqs, output int overlaps);
    int r0, o0;
    @(negedge clk);
    r0 = req_total;
    o0 = overlap_total;
    start   = 1'b1;
    head_in = h;
    mode_in = m;
    @(posedge clk);
    #1;
    cycles = 1;
    while (!done && cycles < 4000) begin
      head_in = 8'($urandom);
      mode_in = 2'($urandom);
      @(posedge clk);
      #1;
      cycles++;
    end
    reqs     = req_total - r0;
    overlaps = overlap_total - o0;
  endtask

  task automatic releaseStart(input string name, input logic [31:0] exp_res);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, ".rel_done"}, {31'd0, done}, 32'd0);
    checkOutput({name, ".rel_result"}, result, exp_res);
  endtask

  task automatic build_list(input int n, input bit make_loop, output logic [7:0] h);
    logic [7:0]  addr [8];
    logic [31:0] nxt32;
    int base, step;
    base = int'($urandom_range(0, 126));
    step = int'($urandom_range(1, 126));
    for (int k = 0; k < n; k++) addr[k] = 8'(2 + 2 * ((base + k * step) % 127));
    for (int k = 0; k < n; k++) begin
      mem[addr[k]] = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
      nxt32 = $urandom;
      if (k < n - 1)      nxt32[7:0] = addr[k + 1];
      else if (make_loop) nxt32[7:0] = addr[$urandom_range(0, n - 1)];
      else                nxt32[7:0] = 8'd0;
      mem[addr[k] + 8'd1] = nxt32;
    end
    h = addr[0];
  endtask

  initial begin
    vec_t        vecs [10];
    int          cyc, reqs, ovl, r0;
    logic [31:0] er;
    logic        eo, ee;
    logic [7:0]  h;
    string       nm;

    rst = 1'b1; start = 1'b0; mode_in = 2'd0; head_in = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[2]  = 32'd5;          mem[3]  = 32'hABCD_000A;
    mem[10] = 32'd7;          mem[11] = 32'd20;
    mem[20] = 32'd9;          mem[21] = 32'h1234_5600;
    mem[30] = 32'hFFFF_FFFF;  mem[31] = 32'd40;
    mem[40] = 32'd2;          mem[41] = 32'd0;
    mem[4]  = 32'h0000_1234;  mem[5]  = 32'hFFFF_FF04;
    mem[255] = 32'h55;        mem[0]  = 32'd2;

    vecs[0] = '{8'd2,   2'd0, 32'd21,       1'b0, 1'b0, 13,  6};
    vecs[1] = '{8'd0,   2'd0, 32'd0,        1'b0, 1'b0, 1,   0};
    vecs[2] = '{8'd0,   2'd3, 32'd0,        1'b0, 1'b0, 1,   0};
    vecs[3] = '{8'd2,   2'd1, 32'd9,        1'b0, 1'b0, 13,  6};
    vecs[4] = '{8'd2,   2'd2, 32'd3,        1'b0, 1'b0, 13,  6};
    vecs[5] = '{8'd2,   2'd3, 32'd11,       1'b0, 1'b0, 13,  6};
    vecs[6] = '{8'd30,  2'd0, 32'd1,        1'b1, 1'b0, 9,   4};
    vecs[7] = '{8'd4,   2'd2, 32'd64,       1'b0, 1'b1, 257, 128};
    vecs[8] = '{8'd255, 2'd0, 32'd106,      1'b0, 1'b0, 17,  8};
    vecs[9] = '{8'd4,   2'd1, 32'h0000_1234, 1'b0, 1'b1, 257, 128};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset.busy",    {31'd0, busy},    32'd0);
    checkOutput("reset.done",    {31'd0, done},    32'd0);
    checkOutput("reset.ovf",     {31'd0, ovf},     32'd0);
    checkOutput("reset.err",     {31'd0, err},     32'd0);
    checkOutput("reset.result",  result,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    spur_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      nm = $sformatf("vec%0d", i);
      lat_max = 1;
      applyStimulus(vecs[i].head, vecs[i].mode, cyc, reqs, ovl);
      checkOutput({nm, ".done"},    {31'd0, done}, 32'd1);
      checkOutput({nm, ".busy"},    {31'd0, busy}, 32'd0);
      checkOutput({nm, ".result"},  result, vecs[i].exp_result);
      checkOutput({nm, ".ovf"},     {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      checkOutput({nm, ".err"},     {31'd0, err}, {31'd0, vecs[i].exp_err});
      checkOutput({nm, ".cycles"},  cyc, vecs[i].exp_cycles);
      checkOutput({nm, ".reqs"},    reqs, vecs[i].exp_reqs);
      releaseStart(nm, vecs[i].exp_result);
    end

    // Same three-node list in the other modes with slow, jittery memory.
    for (int m = 1; m < 4; m++) begin
      nm = $sformatf("slow_mode%0d", m);
      lat_max = 5;
      ref_walk(8'd2, 2'(m), er, eo, ee);
      applyStimulus(8'd2, 2'(m), cyc, reqs, ovl);
      checkOutput({nm, ".done"},     {31'd0, done}, 32'd1);
      checkOutput({nm, ".result"},   result, er);
      checkOutput({nm, ".overlap"},  ovl, 32'd0);
      checkOutput({nm, ".reqs"},     reqs, 32'd6);
      releaseStart(nm, er);
    end

    // Reset while waiting on the next pointer of the second node.
    lat_max = 3;
    @(negedge clk);
    r0 = req_total;
    start = 1'b1; head_in = 8'd2; mode_in = 2'd0;
    cyc = 0;
    while ((req_total - r0) < 4 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("rst_mid.reached", req_total - r0, 32'd4);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid.busy",    {31'd0, busy},    32'd0);
    checkOutput("rst_mid.done",    {31'd0, done},    32'd0);
    checkOutput("rst_mid.result",  result,           32'd0);
    checkOutput("rst_mid.mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat_max = 1;
    applyStimulus(8'd2, 2'd0, cyc, reqs, ovl);
    checkOutput("rst_after.result", result, 32'd21);
    checkOutput("rst_after.cycles", cyc, 32'd13);
    releaseStart("rst_after", 32'd21);

    for (int t = 0; t < 24; t++) begin
      nm = $sformatf("rand%0d", t);
      build_list(int'($urandom_range(1, 8)), ($urandom_range(0, 4) == 0), h);
      mode_in = 2'd0;
      lat_max = int'($urandom_range(1, 5));
      ref_walk(h, 2'(t % 4), er, eo, ee);
      applyStimulus(h, 2'(t % 4), cyc, reqs, ovl);
      checkOutput({nm, ".done"},    {31'd0, done}, 32'd1);
      checkOutput({nm, ".result"},  result, er);
      checkOutput({nm, ".ovf"},     {31'd0, ovf}, {31'd0, eo});
      checkOutput({nm, ".err"},     {31'd0, err}, {31'd0, ee});
      checkOutput({nm, ".overlap"}, ovl, 32'd0);
      releaseStart(nm, er);
    end

    $display("Result: errors=%0d of %0d checks", err_count, chk_total);
    $finish;
  end

endmodule

// File: doc/list_reduce_engine.md
Name: list_reduce_engine

Overview:
- Parametrised linked-list traversal and reduction engine, the successor to the single-mode list-sum controller.
- Walks a null-terminated list held in a single-port read memory and folds node values with a selectable operation (sum, max, count, xor).
- Integrates controller and datapath in one block and adds a variable-latency memory handshake, a node-count limit for cycle/runaway protection, and an overflow flag.
- Sits between the top-level control register (start/mode/head) and the shared list memory.

Parameters:
DATA_W, 32, width of node value and result
ADDR_W, 8, width of node pointers and memory address
MAX_NODES, 64, traversal limit; exceeding it aborts with err

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  level request; sampled only in IDLE; must stay high until done is observed
mode  in  2  00 sum, 01 max (unsigned), 10 count, 11 xor; latched at start
head  in  ADDR_W  pointer to first node; 0 = null; latched at start
mem_req  out  1  one-cycle read request
mem_addr  out  ADDR_W  read address, valid while mem_req=1
mem_rvalid  in  1  read data valid; at least 1 cycle after mem_req; one outstanding read max
mem_rdata  in  DATA_W  read data; pointer fields use low ADDR_W bits
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE
result  out  DATA_W  reduction result, stable while done=1
ovf  out  1  sum/count wrapped at least once (sticky per run)
err  out  1  node limit exceeded; result holds the partial value

Behaviour:
- Node layout: mem[p] = value, mem[p+1] = next pointer (low ADDR_W bits of rdata). p+1 wraps modulo 2^ADDR_W. Pointer 0 terminates the list.
- Reset: state=IDLE; mem_req, busy, done, ovf, err = 0; result = 0; node counter = 0. All outputs are registered.
- States:
  - IDLE: if start=1, latch mode and head, clear acc/ovf/err/count, set busy.
    - head==0 -> DONE.
    - else -> REQ_VAL.
  - REQ_VAL: mem_req=1, mem_addr=ptr -> WAIT_VAL.
  - WAIT_VAL: hold until mem_rvalid.
    - acc <= f(acc, rdata); count++.
    - -> REQ_NEXT.
  - REQ_NEXT: mem_req=1, mem_addr=ptr+1 -> WAIT_NEXT.
  - WAIT_NEXT: on mem_rvalid, ptr <= rdata[ADDR_W-1:0].
    - ptr==0 -> DONE.
    - count==MAX_NODES -> ERR_DONE, err=1.
    - else -> REQ_VAL.
  - DONE / ERR_DONE (one encoding plus err bit): busy=0, done=1, result=acc. Remain until start=0, then -> IDLE with done cleared. Result and flags hold until the next accepted start.
- Reduction f (acc identity is 0 for all modes):
  - sum: acc+value mod 2^DATA_W; ovf set on carry-out.
  - max: unsigned max.
  - count: acc+1, value ignored; ovf on wrap.
  - xor: acc^value.
- Latency: with 1-cycle memory, each node costs 4 cycles. An N-node list gives done at 4N+1 cycles after the start-sampling edge; empty list gives 1 cycle.
- Boundary cases:
  - mem_rvalid outside the WAIT states is ignored.
  - Changes to start, mode or head while busy are ignored.
  - rst mid-traversal returns to IDLE next edge with all outputs cleared. The memory model shares rst and drops any outstanding read.
  - A self-loop (next==p) terminates via the MAX_NODES limit.

Decomposition:
- Package list_reduce_pkg holds:
  - state_t enum: IDLE, REQ_VAL, WAIT_VAL, REQ_NEXT, WAIT_NEXT, DONE.
  - mode_t enum: MODE_SUM, MODE_MAX, MODE_CNT, MODE_XOR.
  - NULL_PTR constant.
- One sub-module, list_reduce_alu: combinational f(acc, value, mode) -> {next_acc, carry}.

Test Plan:
- Sum, nodes at 2->10->20, values 5, 7, 9, next 10, 20, 0; 1-cycle memory -> result=21, done at cycle 13, ovf=0, err=0.
- head=0, any mode -> done 1 cycle after start, result=0, no mem_req issued.
- Same list, mode=max, then mode=count, then mode=xor; memory latency randomised 1-5 cycles -> results 9, 3, 5^7^9=11; mem_req never re-issued while a read is outstanding.
- Sum, DATA_W=32, values 0xFFFFFFFF and 0x2 -> result=0x1, ovf=1.
- Self-loop at p=4 (mem[5]=4), MAX_NODES=64 -> err=1, done=1, count mode result=64.
- rst asserted in WAIT_NEXT of node 2 -> next cycle busy=0, done=0, result=0. A new start then completes correctly.
